// File: rtl/ram_copy_engine_pkg.sv
// ---------------------------------------------------------------------------
// ram_copy_engine_pkg
// Shared definitions for the RAM copy/fill engine: FSM state encoding,
// command mode constants and default geometry of the 256x64 RAM.
// ---------------------------------------------------------------------------
package ram_copy_engine_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = ADDR_W_DEF + 1;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// ---------------------------------------------------------------------------
// ram_copy_engine
// Requester-side master for a single-port synchronous RAM with a 1-cycle
// registered read. Executes a block COPY (memmove semantics) or a FILL with
// a constant pattern over an address range that wraps modulo 2**ADDR_W.
//
// Ports
//   clock        in   single clock, all state on posedge
//   reset        in   asynchronous, active-high; clears all state/outputs
//   start        in   command strobe, sampled only while idle
//   mode         in   0 = COPY, 1 = FILL (captured with start)
//   src_addr     in   COPY source base (captured with start)
//   dst_addr     in   destination base (captured with start)
//   length       in   word count 0..2**ADDR_W (captured with start)
//   pattern      in   FILL data (captured with start)
//   busy         out  high while the command is executing
//   done         out  one-cycle completion pulse
//   ram_address  out  RAM address
//   ram_write    out  RAM write enable
//   ram_in       out  RAM write data
//   ram_out      in   RAM read data, valid the cycle after its address
// ---------------------------------------------------------------------------
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] STEP_UP   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] STEP_DOWN = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            state_r, state_s;
  logic              mode_r, mode_s;
  logic [LEN_W-1:0]  count_r, count_s;
  logic [ADDR_W-1:0] src_ptr_r, src_ptr_s;
  logic [ADDR_W-1:0] dst_ptr_r, dst_ptr_s;
  logic              desc_r, desc_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              write_r, write_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;

  // Command decode helpers: direction and first word of a new command.
  logic              new_desc_s;
  logic [ADDR_W-1:0] offset_s;
  logic [ADDR_W-1:0] first_src_s;
  logic [ADDR_W-1:0] first_dst_s;
  logic [ADDR_W-1:0] step_s;

  // Command decode: an overlapping forward move must run from the top down
  // so that source words are read before they are overwritten.
  always_comb begin
    new_desc_s  = (mode == MODE_COPY) && (dst_addr > src_addr);
    if (new_desc_s) begin
      offset_s = length[ADDR_W-1:0] - STEP_UP;
    end else begin
      offset_s = ADDR_ZERO;
    end
    first_src_s = src_addr + offset_s;
    first_dst_s = dst_addr + offset_s;
    if (desc_r) begin
      step_s = STEP_DOWN;
    end else begin
      step_s = STEP_UP;
    end
  end

  // Next-state and next-output logic; every output is computed here and
  // registered below so the RAM sees glitch-free, edge-aligned controls.
  always_comb begin
    state_s   = state_r;
    mode_s    = mode_r;
    count_s   = count_r;
    src_ptr_s = src_ptr_r;
    dst_ptr_s = dst_ptr_r;
    desc_s    = desc_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    addr_s    = addr_r;
    write_s   = 1'b0;
    wdata_s   = wdata_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_s = mode;
          if (length != LEN_ZERO) begin
            count_s   = length;
            src_ptr_s = first_src_s;
            dst_ptr_s = first_dst_s;
            desc_s    = new_desc_s;
            busy_s    = 1'b1;
            if (mode == MODE_COPY) begin
              state_s = ST_RD;
              addr_s  = first_src_s;
            end else begin
              // ram_in carries the pattern for the whole fill.
              state_s = ST_WR;
              addr_s  = first_dst_s;
              write_s = 1'b1;
              wdata_s = pattern;
            end
          end else begin
            state_s = ST_FIN;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RD: begin
        // Address already on the bus; RAM registers the read this edge.
        state_s = ST_LAT;
      end

      ST_LAT: begin
        state_s = ST_WR;
        wdata_s = ram_out;
        addr_s  = dst_ptr_r;
        write_s = 1'b1;
      end

      ST_WR: begin
        count_s   = count_r - LEN_ONE;
        src_ptr_s = src_ptr_r + step_s;
        dst_ptr_s = dst_ptr_r + step_s;
        if (count_r == LEN_ONE) begin
          state_s = ST_FIN;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else if (mode_r == MODE_COPY) begin
          state_s = ST_RD;
          addr_s  = src_ptr_r + step_s;
        end else begin
          state_s = ST_WR;
          addr_s  = dst_ptr_r + step_s;
          write_s = 1'b1;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any command at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mode_r    <= MODE_COPY;
      count_r   <= LEN_ZERO;
      src_ptr_r <= ADDR_ZERO;
      dst_ptr_r <= ADDR_ZERO;
      desc_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      addr_r    <= ADDR_ZERO;
      write_r   <= 1'b0;
      wdata_r   <= DATA_ZERO;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      count_r   <= count_s;
      src_ptr_r <= src_ptr_s;
      dst_ptr_r <= dst_ptr_s;
      desc_r    <= desc_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      addr_r    <= addr_s;
      write_r   <= write_s;
      wdata_r   <= wdata_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign ram_address = addr_r;
  assign ram_write   = write_r;
  assign ram_in      = wdata_r;

endmodule

// File: tb/tb_ram_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_ram_copy_engine
// Drives ram_copy_engine against a behavioural 256x64 RAM (registered read)
// and checks it against a word-level memmove/fill model plus a per-cycle
// schedule of when each read/write must appear on the RAM port.
// ---------------------------------------------------------------------------
module tb_ram_copy_engine;
  import ram_copy_engine_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  length;
  logic [63:0] pattern;
  logic        busy;
  logic        done;
  logic [7:0]  ram_address;
  logic        ram_write;
  logic [63:0] ram_in;
  logic [63:0] ram_out;

  logic        load_en;
  logic [7:0]  load_addr;
  logic [63:0] load_data;

  logic [63:0] mem       [256];
  logic [63:0] model_mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  ram_copy_engine dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_write   (ram_write),
    .ram_in      (ram_in),
    .ram_out     (ram_out)
  );

  // RAM256x64 responder with a bench-side preload port.
  always @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (ram_write) mem[ram_address] <= ram_in;
    ram_out <= mem[ram_address];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic poke(input logic [7:0] a, input logic [63:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    model_mem[a] = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic mem_compare(input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_mem[k]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  // One command: builds the expected word order from memmove/fill rules,
  // then checks every cycle from acceptance to one cycle past done.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input int n, input logic [63:0] pat, input bit inject,
                         output int lat, output int writes);
    logic [7:0]  wa [256];
    logic [7:0]  ra [256];
    logic [63:0] wd [256];
    bit          desc;
    bit          exp_w;
    int          dur;
    int          idx;
    int          j;
    desc = (m == MODE_COPY) && (d > s);
    for (int k = 0; k < n; k++) begin
      idx   = desc ? (n - 1 - k) : k;
      wa[k] = d + 8'(idx);
      ra[k] = s + 8'(idx);
      wd[k] = (m == MODE_FILL) ? pat : model_mem[ra[k]];
    end
    dur = (m == MODE_FILL) ? n : 3 * n;

    @(negedge clock);
    mode = m; src_addr = s; dst_addr = d; length = 9'(n); pattern = pat; start = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    mode     = 1'($urandom);
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    length   = 9'($urandom_range(0, 256));
    pattern  = {$urandom(), $urandom()};

    lat = -1;
    writes = 0;
    for (int t = 0; t <= dur + 1; t++) begin
      if (t > 0) begin @(posedge clock); #1; end
      if (inject && dur > 3 && t == 2) begin
        mode = ~m; length = 9'd7; start = 1'b1;
      end
      if (inject && dur > 3 && t == 3) start = 1'b0;
      if (done === 1'b1 && lat < 0) lat = t + 1;
      check("busy", 64'(busy), 64'(t < dur));
      check("done", 64'(done), 64'(t == dur));
      exp_w = (m == MODE_FILL) ? (t < n) : ((t < 3 * n) && (t % 3 == 2));
      check("ram_write", 64'(ram_write), 64'(exp_w));
      if (ram_write === 1'b1) writes++;
      if (exp_w) begin
        j = (m == MODE_FILL) ? t : t / 3;
        check("wr_addr", 64'(ram_address), 64'(wa[j]));
        check("wr_data", ram_in, wd[j]);
      end else if (m == MODE_COPY && t < 3 * n) begin
        check("rd_addr", 64'(ram_address), 64'(ra[t / 3]));
      end
    end
    check("write_count", 64'(writes), 64'(n));
    check("done_latency", 64'(lat), 64'(dur + 1));
    for (int k = 0; k < n; k++) model_mem[wa[k]] = wd[k];
    mem_compare("mem_image");
  endtask

  initial begin
    int lat;
    int wr;
    int len;
    int r;
    logic [63:0] pat;

    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = 8'd0; dst_addr = 8'd0;
    length = 9'd0; pattern = 64'd0; load_en = 1'b0; load_addr = 8'd0; load_data = 64'd0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ram_write", 64'(ram_write), 64'd0);
    check("rst_ram_address", 64'(ram_address), 64'd0);
    check("rst_ram_in", ram_in, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 256; k++) poke(8'(k), {$urandom(), $urandom()});

    // 1: plain COPY
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), 64'hA0 + 64'(i));
    run_cmd(MODE_COPY, 8'h10, 8'h40, 4, 64'd0, 1'b0, lat, wr);
    check("t1_latency", 64'(lat), 64'd13);
    for (int i = 0; i < 4; i++) check("t1_dst", mem[8'h40 + 8'(i)], 64'hA0 + 64'(i));

    // 2: overlapping COPY both ways
    run_cmd(MODE_COPY, 8'h10, 8'h11, 4, 64'd0, 1'b0, lat, wr);
    check("t2_up_10", mem[8'h10], 64'hA0);
    check("t2_up_11", mem[8'h11], 64'hA0);
    check("t2_up_14", mem[8'h14], 64'hA3);
    run_cmd(MODE_COPY, 8'h11, 8'h10, 4, 64'd0, 1'b0, lat, wr);
    check("t2_dn_10", mem[8'h10], 64'hA0);
    check("t2_dn_13", mem[8'h13], 64'hA3);
    check("t2_dn_14", mem[8'h14], 64'hA3);

    // 3: FILL across the wrap point
    poke(8'h02, 64'h0000_0000_0000_0202);
    run_cmd(MODE_FILL, 8'h00, 8'hFE, 4, 64'hDEAD_BEEF_0000_0001, 1'b0, lat, wr);
    check("t3_latency", 64'(lat), 64'd5);
    check("t3_fe", mem[8'hFE], 64'hDEAD_BEEF_0000_0001);
    check("t3_01", mem[8'h01], 64'hDEAD_BEEF_0000_0001);
    check("t3_02_kept", mem[8'h02], 64'h0000_0000_0000_0202);

    // 4: zero length and full-memory FILL
    run_cmd(MODE_COPY, 8'h30, 8'h50, 0, 64'd0, 1'b0, lat, wr);
    check("t4_len0_latency", 64'(lat), 64'd1);
    check("t4_len0_writes", 64'(wr), 64'd0);
    run_cmd(MODE_FILL, 8'h00, 8'h00, 256, 64'h5A5A_0000_FFFF_1234, 1'b0, lat, wr);
    check("t4_fill256_writes", 64'(wr), 64'd256);

    // 5: start while busy is ignored
    for (int i = 0; i < 4; i++) poke(8'h80 + 8'(i), 64'hC0 + 64'(i));
    run_cmd(MODE_COPY, 8'h80, 8'h90, 4, 64'd0, 1'b1, lat, wr);
    check("t5_93", mem[8'h93], 64'hC3);

    // 6: reset in the LAT cycle of the third word
    for (int i = 0; i < 4; i++) poke(8'h60 + 8'(i), 64'hE0 + 64'(i));
    for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 64'hF0 + 64'(i));
    @(negedge clock);
    mode = MODE_COPY; src_addr = 8'h60; dst_addr = 8'h20; length = 9'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    check("t6_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_ram_write", 64'(ram_write), 64'd0);
    check("t6_ram_address", 64'(ram_address), 64'd0);
    @(posedge clock); #1;
    check("t6_ram_write_held", 64'(ram_write), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    check("t6_w0", mem[8'h20], 64'hE0);
    check("t6_w1", mem[8'h21], 64'hE1);
    check("t6_w2_kept", mem[8'h22], 64'hF2);
    check("t6_w3_kept", mem[8'h23], 64'hF3);
    model_mem[8'h20] = 64'hE0;
    model_mem[8'h21] = 64'hE1;
    mem_compare("t6_mem_image");
    run_cmd(MODE_FILL, 8'h00, 8'h22, 2, 64'h1111_2222_3333_4444, 1'b0, lat, wr);
    check("t6_restart", mem[8'h23], 64'h1111_2222_3333_4444);

    // Randomised commands
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 0, 64'd0, 1'b0, lat, wr);
      end else if (r < 5) begin
        len = $urandom_range(1, 40);
        pat = {$urandom(), $urandom()};
        run_cmd(MODE_FILL, 8'd0, 8'($urandom), len, pat, 1'b0, lat, wr);
      end else begin
        len = $urandom_range(1, 32);
        run_cmd(MODE_COPY, 8'($urandom_range(0, 256 - len)), 8'($urandom_range(0, 256 - len)),
                len, 64'd0, 1'($urandom_range(0, 1)), lat, wr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
